sonar_echo_responder: RTL and testbench
=======================================

// Module: sonar_echo_responder
// PURPOSE
//  Bus-programmable model of an HC-SR04-style ultrasonic sensor, i.e. the far end of the sonar trig/echo interface.
//  Watches trig; after a valid trigger pulse it drives echo high for a width equal to the programmed range in inches.
//  Used for hardware-in-loop checking of the sonar peripheral without a physical sensor.
//  Sits on the same 8-bit peripheral bus as the other I/O blocks.
// PARAMETERS
//  F_CPU          16000000  clock frequency in Hz. 1 us tick = ceil(F_CPU/1e6) clocks.
//  RESP_ADDRESS   8'h00     base bus address. CONTROL=+0, RANGE=+1, PINGS=+2.
//  MIN_TRIG_US    10        minimum trig high width, in us, accepted as a trigger.
//  ECHO_DELAY_US  250       gap from the trig falling edge to the echo rising edge, in us.
//  US_PER_INCH    149       echo width per inch of range, in us.
//  NO_OBJ_US      38000     echo width when RANGE==0 or CONTROL[1]=1.
//  CYCLE_US       60000     minimum time from echo rise to re-arm, in us.
// PORTS
//  clk      in   1  system clock
//  rst_n    in   1  asynchronous, active-low reset
//  din      in   8  bus write data
//  address  in   8  bus address
//  w_en     in   1  bus write strobe, 1 clk
//  r_en     in   1  bus read strobe, 1 clk
//  dout     out  8  bus read data, registered
//  trig     in   1  trigger from the sonar master. Asynchronous input.
//  echo     out  1  echo pulse to the sonar master, registered
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - echo=0, dout=0.
//   - CONTROL, RANGE, PINGS, counters and prescaler all 0.
//   - FSM goes to IDLE.
//  Bus:
//   - r_en at a mapped address: dout <= register on the next clk.
//   - Any cycle with an unmapped address: dout <= 0.
//   - Any other cycle: dout holds.
//   - CONTROL[0]=enable, CONTROL[1]=force no-object, CONTROL[2]=busy (read-only, 1 when FSM!=IDLE).
//     CONTROL[7:3] read 0.
//   - RANGE is read/write.
//   - PINGS counts accepted triggers and wraps 255->0. Any write to PINGS clears it. If a clear and an increment fall in the same clk, the clear wins.
//  trig path:
//   - trig passes through a 2-flop synchronizer; edges are detected on the synchronized signal.
//  Prescaler:
//   - Free-running, emits a 1-clk tick every ceil(F_CPU/1e6) clocks.
//   - All us counting advances on ticks only. A 16-bit us counter saturates.
//  FSM:
//   - IDLE:
//     - On a synchronized trig rise with enable=1: clear the width counter, go to TRIG.
//   - TRIG:
//     - Count ticks while trig is high (8-bit, saturating).
//     - On trig fall: if width >= MIN_TRIG_US, increment PINGS, latch N, clear the counter, go to DELAY.
//       Otherwise go to IDLE with no echo.
//     - N = NO_OBJ_US if RANGE==0 or CONTROL[1]=1; otherwise N = RANGE*US_PER_INCH (16-bit, max 37995).
//   - DELAY:
//     - After ECHO_DELAY_US ticks: echo<=1, clear the counter, go to ECHO.
//   - ECHO:
//     - After N ticks: echo<=0, go to HOLD. The counter keeps running.
//     - Echo width is N us +0/-1 tick of prescaler phase.
//   - HOLD:
//     - When the counter reaches CYCLE_US-1: go to IDLE.
//     - trig is ignored in DELAY, ECHO and HOLD.
//  Boundary cases:
//   - RANGE written mid-cycle: the current pulse is unaffected; the new value applies from the next trigger.
//   - enable cleared in any state: echo<=0 and FSM<=IDLE on the next clk. Counters clear.
//   - Trig held high beyond 255 us: the width saturates, and the trigger is still accepted on fall.
//   - rst_n asserted mid-echo: echo drops immediately (asynchronous).
// TESTING
//  (F_CPU=16 MHz, so 1 us = 16 clk.)
//  1. enable=1, RANGE=10, trig high 10 us -> echo rises 250 us after trig fall, is high 1490 us (23840 clk +0/-16), PINGS=1.
//  2. trig high 5 us -> no echo, PINGS unchanged, busy returns to 0.
//  3. RANGE=0 (and separately CONTROL[1]=1 with RANGE=50), valid trig -> echo width 38000 us.
//  4. Second trig at 20 ms after echo rise -> ignored. Trig at 61 ms -> accepted, PINGS increments.
//  5. Write RANGE=200 mid-echo with RANGE=10 -> current pulse is 1490 us, next pulse is 29800 us.
//     Write PINGS -> PINGS reads 0.
//  6. rst_n=0 mid-echo -> echo=0 and all registers 0 at once. Clear enable mid-echo -> echo=0 next clk.

Source files
------------

// File: rtl/sonar_echo_responder.sv
// Bus-programmable HC-SR04 style echo responder: watches trig and answers
// with an echo pulse whose width encodes the programmed range.
module sonar_echo_responder #(
    parameter int unsigned F_CPU         = 16000000,
    parameter logic [7:0]  RESP_ADDRESS  = 8'h00,
    parameter int unsigned MIN_TRIG_US   = 10,
    parameter int unsigned ECHO_DELAY_US = 250,
    parameter int unsigned US_PER_INCH   = 149,
    parameter int unsigned NO_OBJ_US     = 38000,
    parameter int unsigned CYCLE_US      = 60000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic       trig,
    output logic       echo
);

    localparam int unsigned TICK_CLKS = (F_CPU + 999999) / 1000000;
    localparam logic [15:0] TICK_LAST = 16'(TICK_CLKS - 1);
    localparam logic [7:0]  MIN_W     = 8'(MIN_TRIG_US);
    localparam logic [15:0] DLY_LAST  = 16'(ECHO_DELAY_US - 1);
    localparam logic [15:0] NO_OBJ    = 16'(NO_OBJ_US);
    localparam logic [15:0] CYC_LAST  = 16'(CYCLE_US - 1);
    localparam logic [15:0] UPI       = 16'(US_PER_INCH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_DELAY,
        S_ECHO,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [15:0] r_presc;
    logic        r_trig_s1;
    logic        r_trig_s2;
    logic        r_trig_d;
    logic [1:0]  r_ctrl;
    logic [7:0]  r_range;
    logic [7:0]  r_pings;
    logic [15:0] r_cnt;
    logic [7:0]  r_width;
    logic [15:0] r_n;

    logic [7:0]  w_off;
    logic        w_sel_ctrl;
    logic        w_sel_range;
    logic        w_sel_pings;
    logic        w_mapped;
    logic        w_wr_ctrl;
    logic        w_wr_range;
    logic        w_wr_pings;
    logic        w_enable;
    logic        w_tick;
    logic        w_rise;
    logic        w_fall;
    logic        w_accept;
    logic        w_busy;
    logic [15:0] w_prod;
    logic [15:0] w_n_calc;
    logic [15:0] w_cnt_inc;
    logic [16:0] w_cnt_next;
    logic [7:0]  w_rdata;

    // Bus decode relative to the base address
    assign w_off       = address - RESP_ADDRESS;
    assign w_sel_ctrl  = (w_off == 8'd0);
    assign w_sel_range = (w_off == 8'd1);
    assign w_sel_pings = (w_off == 8'd2);
    assign w_mapped    = w_sel_ctrl | w_sel_range | w_sel_pings;
    assign w_wr_ctrl   = w_en & w_sel_ctrl;
    assign w_wr_range  = w_en & w_sel_range;
    assign w_wr_pings  = w_en & w_sel_pings;

    // Enable as it will be after this clk, so a clearing write acts at once
    assign w_enable = w_wr_ctrl ? din[0] : r_ctrl[0];

    assign w_tick = (r_presc == TICK_LAST);
    assign w_rise = r_trig_s2 & ~r_trig_d;
    assign w_fall = ~r_trig_s2 & r_trig_d;
    assign w_busy = (r_state != S_IDLE);

    assign w_accept = (r_state == S_TRIG) & w_fall & w_enable
                    & (r_width >= MIN_W);

    assign w_prod   = {8'd0, r_range} * UPI;
    assign w_n_calc = ((r_range == 8'd0) || r_ctrl[1]) ? NO_OBJ : w_prod;

    assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_cnt_next = {1'b0, r_cnt} + 17'd1;

    always_comb begin
        w_rdata = 8'h00;
        unique case (1'b1)
            w_sel_ctrl:  w_rdata = {5'd0, w_busy, r_ctrl};
            w_sel_range: w_rdata = r_range;
            w_sel_pings: w_rdata = r_pings;
            default:     w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 16'd0;
        end else if (w_tick) begin
            r_presc <= 16'd0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
            r_trig_d  <= 1'b0;
        end else begin
            r_trig_s1 <= trig;
            r_trig_s2 <= r_trig_s1;
            r_trig_d  <= r_trig_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl  <= 2'd0;
            r_range <= 8'd0;
            r_pings <= 8'd0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= din[1:0];
            end
            if (w_wr_range) begin
                r_range <= din;
            end
            if (w_wr_pings) begin
                r_pings <= 8'd0;
            end else if (w_accept) begin
                r_pings <= r_pings + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'h00;
        end else if (!w_mapped) begin
            dout <= 8'h00;
        end else if (r_en) begin
            dout <= w_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            echo    <= 1'b0;
            r_cnt   <= 16'd0;
            r_width <= 8'd0;
            r_n     <= 16'd0;
        end else if (!w_enable) begin
            r_state <= S_IDLE;
            echo    <= 1'b0;
            r_cnt   <= 16'd0;
            r_width <= 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_width <= 8'd0;
                        r_cnt   <= 16'd0;
                        r_state <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (w_fall) begin
                        if (r_width >= MIN_W) begin
                            r_n     <= w_n_calc;
                            r_cnt   <= 16'd0;
                            r_state <= S_DELAY;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_tick && (r_width != 8'hFF)) begin
                        r_width <= r_width + 8'd1;
                    end
                end
                S_DELAY: begin
                    if (w_tick) begin
                        if (r_cnt >= DLY_LAST) begin
                            echo    <= 1'b1;
                            r_cnt   <= 16'd0;
                            r_state <= S_ECHO;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_ECHO: begin
                    if (w_tick) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_next >= {1'b0, r_n}) begin
                            echo    <= 1'b0;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Counter still runs from echo rise to enforce the cycle time
                    if (r_cnt >= CYC_LAST) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    echo    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_echo_responder.sv
// Self-checking bench for sonar_echo_responder with scaled timing
// (1.5 MHz clock rounds up to 2 clk per us).
module tb_sonar_echo_responder;

    localparam int T = 2;
    localparam int DLY = 25;
    localparam logic [7:0] A_CTRL  = 8'h40;
    localparam logic [7:0] A_RANGE = 8'h41;
    localparam logic [7:0] A_PINGS = 8'h42;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] address = A_CTRL;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] dout;
    logic       trig = 1'b0;
    logic       echo;

    sonar_echo_responder #(
        .F_CPU(1500000),
        .RESP_ADDRESS(8'h40),
        .MIN_TRIG_US(10),
        .ECHO_DELAY_US(DLY),
        .US_PER_INCH(7),
        .NO_OBJ_US(500),
        .CYCLE_US(1500)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .address(address),
        .w_en(w_en),
        .r_en(r_en),
        .dout(dout),
        .trig(trig),
        .echo(echo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int width_us;
        int t_fall;
    } exp_t;

    typedef struct {
        logic       en;
        logic       force_no;
        logic [7:0] range;
        int         trig_us;
        logic       acc;
        int         width_us;
    } vec_t;

    exp_t exp_q[$];
    int   meas_r[$];
    int   meas_w[$];
    logic prev_echo = 1'b0;
    int   rise_cyc = 0;

    always @(negedge clk) begin
        if (echo && !prev_echo) begin
            rise_cyc = cyc;
            meas_r.push_back(cyc);
        end
        if (!echo && prev_echo) meas_w.push_back(cyc - rise_cyc);
        prev_echo = echo;
    end

    int total = 0;
    int bad = 0;
    int exp_pings = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        din = d;
        w_en = 1'b1;
        @(negedge clk);
        w_en = 1'b0;
        address = A_CTRL;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        r_en = 1'b1;
        @(negedge clk);
        r_en = 1'b0;
        d = dout;
        address = A_CTRL;
    endtask

    task automatic pulse_trig(input int us, input bit push, input int w);
        exp_t e;
        @(negedge clk);
        trig = 1'b1;
        repeat (us * T) @(negedge clk);
        trig = 1'b0;
        if (push) begin
            e.width_us = w;
            e.t_fall = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        logic [7:0] d;
        bit done;
        done = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 20000 && !done; i++) begin
            bus_rd(A_CTRL, d);
            if (!d[2]) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_idle_timeout: busy stuck at 1 want 0", name);
        end
    endtask

    task automatic wait_rise(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (echo) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_rise_timeout: echo 0 want 1", name);
        end
    endtask

    task automatic check_echoes(input string name);
        exp_t e;
        int w;
        int r;
        while (meas_w.size() > 0) begin
            w = meas_w.pop_front();
            r = (meas_r.size() > 0) ? meas_r.pop_front() : 0;
            if (exp_q.size() == 0) begin
                chk({name, "_unexpected_echo_width"}, w, 0);
            end else begin
                e = exp_q.pop_front();
                chk_rng({name, "_width"}, w,
                        e.width_us * T - T, e.width_us * T);
                chk_rng({name, "_delay"}, r - e.t_fall,
                        (DLY - 1) * T, DLY * T + 4);
            end
        end
        chk({name, "_missing_echo"}, exp_q.size(), 0);
        exp_q.delete();
        meas_r.delete();
    endtask

    task automatic chk_reg(input string name, input logic [7:0] a,
                           input int req);
        logic [7:0] d;
        bus_rd(a, d);
        chk(name, int'(d), req);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'd10,  12,  1'b1, 70};
        vecs[1] = '{1'b1, 1'b0, 8'd10,  5,   1'b0, 0};
        vecs[2] = '{1'b1, 1'b0, 8'd0,   12,  1'b1, 500};
        vecs[3] = '{1'b1, 1'b1, 8'd50,  12,  1'b1, 500};
        vecs[4] = '{1'b1, 1'b0, 8'd3,   300, 1'b1, 21};
        vecs[5] = '{1'b0, 1'b0, 8'd10,  12,  1'b0, 0};
        vecs[6] = '{1'b1, 1'b0, 8'd255, 12,  1'b1, 1785};

        #23;
        chk("reset_echo", int'(echo), 0);
        chk("reset_dout", int'(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_reg("reset_ctrl", A_CTRL, 0);
        chk_reg("reset_range", A_RANGE, 0);
        chk_reg("reset_pings", A_PINGS, 0);

        bus_wr(A_RANGE, 8'hA5);
        chk_reg("range_rw", A_RANGE, 8'hA5);
        @(negedge clk);
        chk("dout_hold", int'(dout), 8'hA5);
        chk_reg("unmapped_rd", 8'h43, 0);
        bus_wr(A_CTRL, 8'hFF);
        chk_reg("ctrl_rw", A_CTRL, 8'h03);

        for (int i = 0; i < 7; i++) begin
            bus_wr(A_CTRL, {6'd0, vecs[i].force_no, vecs[i].en});
            bus_wr(A_RANGE, vecs[i].range);
            pulse_trig(vecs[i].trig_us, vecs[i].acc, vecs[i].width_us);
            if (vecs[i].acc) exp_pings++;
            wait_idle($sformatf("vec%0d", i));
            check_echoes($sformatf("vec%0d", i));
            chk_reg($sformatf("vec%0d_pings", i), A_PINGS, exp_pings);
        end

        bus_wr(A_CTRL, 8'h01);
        bus_wr(A_RANGE, 8'd10);
        pulse_trig(12, 1, 70);
        exp_pings++;
        wait_rise("rearm");
        repeat (500 * T) @(negedge clk);
        chk_reg("rearm_busy", A_CTRL, 8'h05);
        pulse_trig(12, 0, 0);
        wait_idle("rearm");
        check_echoes("rearm_ignored");
        chk_reg("rearm_pings_ign", A_PINGS, exp_pings);
        pulse_trig(12, 1, 70);
        exp_pings++;
        wait_idle("rearm2");
        check_echoes("rearm_accept");
        chk_reg("rearm_pings_acc", A_PINGS, exp_pings);

        pulse_trig(12, 1, 70);
        exp_pings++;
        wait_rise("midrange");
        bus_wr(A_RANGE, 8'd100);
        wait_idle("midrange");
        check_echoes("midrange_cur");
        pulse_trig(12, 1, 700);
        exp_pings++;
        wait_idle("midrange2");
        check_echoes("midrange_next");
        chk_reg("pings_pre_clr", A_PINGS, exp_pings);
        bus_wr(A_PINGS, 8'h5A);
        chk_reg("pings_clr", A_PINGS, 0);

        bus_wr(A_RANGE, 8'd10);
        pulse_trig(12, 0, 0);
        wait_rise("rst_mid");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_echo", int'(echo), 0);
        chk("rst_mid_dout", int'(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_reg("rst_mid_ctrl", A_CTRL, 0);
        chk_reg("rst_mid_range", A_RANGE, 0);
        chk_reg("rst_mid_pings", A_PINGS, 0);
        meas_r.delete();
        meas_w.delete();
        exp_q.delete();

        bus_wr(A_CTRL, 8'h01);
        bus_wr(A_RANGE, 8'd10);
        pulse_trig(12, 0, 0);
        wait_rise("dis_mid");
        repeat (10) @(negedge clk);
        chk("dis_mid_echo_hi", int'(echo), 1);
        bus_wr(A_CTRL, 8'h00);
        chk("dis_mid_echo_lo", int'(echo), 0);
        chk_reg("dis_mid_ctrl", A_CTRL, 0);
        chk_reg("dis_mid_pings", A_PINGS, 1);
        repeat (4) @(negedge clk);
        meas_r.delete();
        meas_w.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
